// File: rtl/mips_mc_pkg.sv
// Shared definitions for the multi-cycle MIPS datapath: widths, control
// encodings, the writeback entry format and the writeback FSM states.
package mips_mc_pkg;

    localparam int MIPS_AW = 5;
    localparam int MIPS_DW = 32;

    // RegDst: which instruction field names the destination register
    localparam logic REGDST_RT    = 1'b0;
    localparam logic REGDST_RD    = 1'b1;

    // MemtoReg: which datapath register supplies the write data
    localparam logic MEMTOREG_ALU = 1'b0;
    localparam logic MEMTOREG_MDR = 1'b1;

    typedef struct packed {
        logic [MIPS_AW-1:0] addr;
        logic [MIPS_DW-1:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        WB_IDLE   = 2'd0,
        WB_ACTIVE = 2'd1,
        WB_HELD   = 2'd2
    } wb_state_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of pending register writes. Entries are also presented
// oldest-first on a flat read-out so the lookup can scan them by age.
module wb_fifo
    import mips_mc_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = wb_entry_t
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      push,
    input  entry_t                    push_entry,
    input  logic                      pop,
    output entry_t                    head,
    output logic [$clog2(DEPTH):0]    count,
    output entry_t [DEPTH-1:0]        entries
);

    localparam int PW = $clog2(DEPTH);

    entry_t        mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so the
    // pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: an entry is only read once count covers it.
    always_ff @(posedge clk) begin
        if (push && !reset && !flush) mem[wr_ptr] <= push_entry;
    end

    assign head = mem[rd_ptr];

    // Age-ordered view: index 0 is the oldest entry.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entries[i] = mem[rd_ptr + PW'(i)];
        end
    end

endmodule

// File: rtl/reg_wb_sequencer.sv
// Write-side sequencer for the register file: accepts writeback requests,
// queues them, retires one write per cycle and answers pending-write lookups.
//
// Handshake: a request transfers on a rising edge where wb_valid and
// wb_ready are both high and flush is low; wb_ready depends only on
// registered occupancy and reset, never on a same-cycle retire.
module reg_wb_sequencer
    import mips_mc_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = MIPS_AW,
    parameter int DW    = MIPS_DW
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wb_valid,
    output logic                    wb_ready,
    input  logic                    wb_dst_sel,
    input  logic                    wb_src_sel,
    input  logic [AW-1:0]           instr_rt,
    input  logic [AW-1:0]           instr_rd,
    input  logic [DW-1:0]           alu_out,
    input  logic [DW-1:0]           mem_data,
    input  logic                    wb_hold,
    input  logic                    flush,
    output logic [AW-1:0]           A3,
    output logic [DW-1:0]           WD3,
    output logic                    RegWrite,
    output logic                    wb_drop,
    output logic [$clog2(DEPTH):0]  pend_count,
    input  logic [AW-1:0]           chk_addr,
    output logic                    chk_hit,
    output logic [DW-1:0]           chk_data,
    output wb_state_t               dbg_state
);

    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } entry_t;

    entry_t             acc_entry;
    entry_t             head;
    entry_t [DEPTH-1:0] q_entries;
    logic               accept;
    logic               push;
    logic               pop;
    logic               last_retire;
    wb_state_t          state;
    wb_state_t          state_nxt;

    assign wb_ready = (pend_count < CW'(DEPTH)) && !reset;
    assign accept   = wb_valid && wb_ready && !flush;

    assign acc_entry.addr = (wb_dst_sel == REGDST_RD)    ? instr_rd : instr_rt;
    assign acc_entry.data = (wb_src_sel == MEMTOREG_MDR) ? mem_data : alu_out;

    // Writes to $0 are architecturally void, so they never occupy a slot.
    assign push = accept && (acc_entry.addr != '0);
    // Retire decision uses registered occupancy, so an accept into an empty
    // queue cannot retire on the same edge.
    assign pop  = (pend_count != '0) && !wb_hold && !flush;

    assign last_retire = pop && !push && (pend_count == CW'(1));

    wb_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .push       (push),
        .push_entry (acc_entry),
        .pop        (pop),
        .head       (head),
        .count      (pend_count),
        .entries    (q_entries)
    );

    // Register-file write port and the $0 drop pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            A3       <= '0;
            WD3      <= '0;
            RegWrite <= 1'b0;
            wb_drop  <= 1'b0;
        end else begin
            wb_drop <= accept && (acc_entry.addr == '0);
            if (pop) begin
                A3       <= head.addr;
                WD3      <= head.data;
                RegWrite <= 1'b1;
            end else begin
                RegWrite <= 1'b0;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state <= WB_IDLE;
        else       state <= state_nxt;
    end

    // FSM next state: tracks empty / draining / held occupancy.
    always_comb begin
        state_nxt = state;
        case (state)
            WB_IDLE: begin
                if (push) state_nxt = WB_ACTIVE;
            end
            WB_ACTIVE: begin
                if (flush || last_retire) state_nxt = WB_IDLE;
                else if (wb_hold)         state_nxt = WB_HELD;
            end
            WB_HELD: begin
                if (flush)        state_nxt = WB_IDLE;
                else if (!wb_hold) state_nxt = last_retire ? WB_IDLE : WB_ACTIVE;
            end
            default: state_nxt = WB_IDLE;
        endcase
    end

    assign dbg_state = state;

    // Lookup: in-flight port is oldest, then queue oldest->youngest; later
    // matches overwrite earlier ones so the youngest write wins.
    always_comb begin
        chk_hit  = 1'b0;
        chk_data = '0;
        if (chk_addr != '0) begin
            if (RegWrite && (A3 == chk_addr)) begin
                chk_hit  = 1'b1;
                chk_data = WD3;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if ((CW'(i) < pend_count) && (q_entries[i].addr == chk_addr)) begin
                    chk_hit  = 1'b1;
                    chk_data = q_entries[i].data;
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_wb_sequencer.sv
// Self-checking bench for reg_wb_sequencer: write scoreboard plus
// per-scenario directed checks.
module tb_reg_wb_sequencer;
    import mips_mc_pkg::*;

    localparam int DEPTH = 2;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    // ---------------- clock / reset / DUT ----------------
    logic            clk;
    logic            reset;
    logic            wb_valid;
    logic            wb_ready;
    logic            wb_dst_sel;
    logic            wb_src_sel;
    logic [AW-1:0]   instr_rt;
    logic [AW-1:0]   instr_rd;
    logic [DW-1:0]   alu_out;
    logic [DW-1:0]   mem_data;
    logic            wb_hold;
    logic            flush;
    logic [AW-1:0]   A3;
    logic [DW-1:0]   WD3;
    logic            RegWrite;
    logic            wb_drop;
    logic [CW-1:0]   pend_count;
    logic [AW-1:0]   chk_addr;
    logic            chk_hit;
    logic [DW-1:0]   chk_data;
    wb_state_t       dbg_state;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    reg_wb_sequencer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_dst_sel (wb_dst_sel),
        .wb_src_sel (wb_src_sel),
        .instr_rt   (instr_rt),
        .instr_rd   (instr_rd),
        .alu_out    (alu_out),
        .mem_data   (mem_data),
        .wb_hold    (wb_hold),
        .flush      (flush),
        .A3         (A3),
        .WD3        (WD3),
        .RegWrite   (RegWrite),
        .wb_drop    (wb_drop),
        .pend_count (pend_count),
        .chk_addr   (chk_addr),
        .chk_hit    (chk_hit),
        .chk_data   (chk_data),
        .dbg_state  (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int               errors = 0;
    int               checks = 0;
    int               m_cnt  = 0;
    logic [AW+DW-1:0] exp_q[$];
    logic [AW+DW-1:0] exp_w;

    // Every cycle the write port is active must match the oldest expected write.
    always @(negedge clk) begin
        if (RegWrite === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected: got A3=%0d WD3=%h, expected no write", A3, WD3);
            end else begin
                exp_w = exp_q.pop_front();
                if ({A3, WD3} !== exp_w) begin
                    errors++;
                    $display("FAIL wb_order: got A3=%0d WD3=%h, expected A3=%0d WD3=%h",
                             A3, WD3, exp_w[AW+DW-1:DW], exp_w[DW-1:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle();
        wb_valid   = 1'b0;
        wb_dst_sel = 1'b0;
        wb_src_sel = 1'b0;
        instr_rt   = '0;
        instr_rd   = '0;
        alu_out    = '0;
        mem_data   = '0;
        flush      = 1'b0;
    endtask

    task automatic set_req(input logic dsel, input logic [AW-1:0] rt, input logic [AW-1:0] rd,
                           input logic ssel, input logic [DW-1:0] alu, input logic [DW-1:0] mem);
        wb_valid   = 1'b1;
        wb_dst_sel = dsel;
        instr_rt   = rt;
        instr_rd   = rd;
        wb_src_sel = ssel;
        alu_out    = alu;
        mem_data   = mem;
    endtask

    // Advance one clock; the reference queue is updated from the inputs
    // that were stable before the edge.
    task automatic tick();
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          acc;
        logic          pop;
        a   = wb_dst_sel ? instr_rd : instr_rt;
        d   = wb_src_sel ? mem_data : alu_out;
        acc = wb_valid && (m_cnt < DEPTH) && !reset && !flush;
        pop = (m_cnt > 0) && !wb_hold && !flush;
        @(posedge clk);
        if (reset || flush) begin
            m_cnt = 0;
            exp_q.delete();
        end else begin
            if (acc && (a != '0)) begin
                exp_q.push_back({a, d});
                m_cnt++;
            end
            if (pop) m_cnt--;
        end
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset    = 1'b1;
        wb_hold  = 1'b0;
        chk_addr = '0;
        idle();
        tick();
        tick();
        checks++; if (wb_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b expected 0", wb_ready); end
        checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL rst_regwrite: got %b expected 0", RegWrite); end
        checks++; if (A3 !== '0 || WD3 !== '0) begin errors++; $display("FAIL rst_port: got A3=%0d WD3=%h expected 0/0", A3, WD3); end
        checks++; if (wb_drop !== 1'b0) begin errors++; $display("FAIL rst_drop: got %b expected 0", wb_drop); end
        checks++; if (pend_count !== '0) begin errors++; $display("FAIL rst_count: got %0d expected 0", pend_count); end
        checks++; if (dbg_state !== WB_IDLE) begin errors++; $display("FAIL rst_state: got %0d expected %0d", dbg_state, WB_IDLE); end
        reset = 1'b0;
        #1;
        checks++; if (wb_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b expected 1", wb_ready); end
        tick();
    endtask

    task automatic test_single();
        set_req(1'b1, 5'd9, 5'd5, 1'b0, 32'h0000_00AA, 32'hFFFF_0000);
        tick();
        idle();
        checks++; if (pend_count !== CW'(1)) begin errors++; $display("FAIL single_count1: got %0d expected 1", pend_count); end
        checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL single_nobypass: got %b expected 0", RegWrite); end
        checks++; if (dbg_state !== WB_ACTIVE) begin errors++; $display("FAIL single_state: got %0d expected %0d", dbg_state, WB_ACTIVE); end
        tick();
        checks++; if (RegWrite !== 1'b1 || A3 !== 5'd5 || WD3 !== 32'h0000_00AA) begin
            errors++; $display("FAIL single_write: got RW=%b A3=%0d WD3=%h expected 1/5/000000aa", RegWrite, A3, WD3);
        end
        checks++; if (pend_count !== '0) begin errors++; $display("FAIL single_count0: got %0d expected 0", pend_count); end
        tick();
        checks++; if (RegWrite !== 1'b0 || A3 !== 5'd5) begin errors++; $display("FAIL single_after: got RW=%b A3=%0d expected 0/5", RegWrite, A3); end
        checks++; if (dbg_state !== WB_IDLE) begin errors++; $display("FAIL single_idle: got %0d expected %0d", dbg_state, WB_IDLE); end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] regs [3];
        logic [DW-1:0] vals [3];
        regs = '{5'd3, 5'd4, 5'd3};
        vals = '{32'h11, 32'h22, 32'h33};
        for (int i = 0; i < 3; i++) begin
            set_req(1'b1, 5'd0, regs[i], 1'b0, vals[i], 32'h0);
            checks++; if (wb_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d: got %b expected 1", i, wb_ready); end
            tick();
            if (i == 1) begin
                // First write in flight, second queued.
                chk_addr = 5'd3; #1;
                checks++; if (chk_hit !== 1'b1 || chk_data !== 32'h11) begin
                    errors++; $display("FAIL b2b_chk_inflight: got hit=%b data=%h expected 1/00000011", chk_hit, chk_data);
                end
                checks++; if (pend_count !== CW'(1)) begin errors++; $display("FAIL b2b_count: got %0d expected 1", pend_count); end
            end
        end
        idle();
        chk_addr = 5'd3; #1;
        checks++; if (chk_hit !== 1'b1 || chk_data !== 32'h33) begin
            errors++; $display("FAIL b2b_chk_youngest: got hit=%b data=%h expected 1/00000033", chk_hit, chk_data);
        end
        chk_addr = 5'd4; #1;
        checks++; if (chk_hit !== 1'b1 || chk_data !== 32'h22) begin
            errors++; $display("FAIL b2b_chk_port: got hit=%b data=%h expected 1/00000022", chk_hit, chk_data);
        end
        tick();
        chk_addr = 5'd4; #1;
        checks++; if (chk_hit !== 1'b0 || chk_data !== '0) begin
            errors++; $display("FAIL b2b_chk_miss: got hit=%b data=%h expected 0/0", chk_hit, chk_data);
        end
        chk_addr = 5'd0; #1;
        checks++; if (chk_hit !== 1'b0) begin errors++; $display("FAIL b2b_chk_zero: got %b expected 0", chk_hit); end
        tick();
        checks++; if (RegWrite !== 1'b0 || pend_count !== '0) begin
            errors++; $display("FAIL b2b_drain: got RW=%b count=%0d expected 0/0", RegWrite, pend_count);
        end
    endtask

    task automatic test_drop();
        set_req(1'b0, 5'd0, 5'd12, 1'b0, 32'hDEAD_BEEF, 32'h0);
        tick();
        idle();
        checks++; if (wb_drop !== 1'b1) begin errors++; $display("FAIL drop_pulse: got %b expected 1", wb_drop); end
        checks++; if (pend_count !== '0 || RegWrite !== 1'b0) begin
            errors++; $display("FAIL drop_noenq: got count=%0d RW=%b expected 0/0", pend_count, RegWrite);
        end
        tick();
        checks++; if (wb_drop !== 1'b0 || RegWrite !== 1'b0) begin
            errors++; $display("FAIL drop_end: got drop=%b RW=%b expected 0/0", wb_drop, RegWrite);
        end
    endtask

    task automatic test_hold_full();
        wb_hold = 1'b1;
        set_req(1'b1, 5'd0, 5'd3, 1'b0, 32'h55, 32'h0);
        tick();
        set_req(1'b0, 5'd3, 5'd0, 1'b1, 32'hDEAD, 32'h66);
        tick();
        checks++; if (pend_count !== CW'(2) || wb_ready !== 1'b0) begin
            errors++; $display("FAIL hold_full: got count=%0d ready=%b expected 2/0", pend_count, wb_ready);
        end
        checks++; if (dbg_state !== WB_HELD) begin errors++; $display("FAIL hold_state: got %0d expected %0d", dbg_state, WB_HELD); end
        chk_addr = 5'd3; #1;
        checks++; if (chk_hit !== 1'b1 || chk_data !== 32'h66) begin
            errors++; $display("FAIL hold_chk_youngest: got hit=%b data=%h expected 1/00000066", chk_hit, chk_data);
        end
        // Offered while full: must not be accepted.
        set_req(1'b1, 5'd0, 5'd6, 1'b0, 32'h77, 32'h0);
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++; if (RegWrite !== 1'b0 || wb_ready !== 1'b0 || pend_count !== CW'(2)) begin
                errors++; $display("FAIL hold_cycle%0d: got RW=%b ready=%b count=%0d expected 0/0/2", c, RegWrite, wb_ready, pend_count);
            end
        end
        idle();
        wb_hold = 1'b0;
        tick();
        checks++; if (RegWrite !== 1'b1 || A3 !== 5'd3 || WD3 !== 32'h55) begin
            errors++; $display("FAIL hold_rel1: got RW=%b A3=%0d WD3=%h expected 1/3/00000055", RegWrite, A3, WD3);
        end
        tick();
        checks++; if (RegWrite !== 1'b1 || A3 !== 5'd3 || WD3 !== 32'h66) begin
            errors++; $display("FAIL hold_rel2: got RW=%b A3=%0d WD3=%h expected 1/3/00000066", RegWrite, A3, WD3);
        end
        tick();
        checks++; if (RegWrite !== 1'b0 || dbg_state !== WB_IDLE) begin
            errors++; $display("FAIL hold_done: got RW=%b state=%0d expected 0/%0d", RegWrite, dbg_state, WB_IDLE);
        end
    endtask

    task automatic test_flush();
        wb_hold = 1'b1;
        set_req(1'b1, 5'd0, 5'd4, 1'b0, 32'hA1, 32'h0);
        tick();
        set_req(1'b1, 5'd0, 5'd5, 1'b0, 32'hA2, 32'h0);
        tick();
        wb_hold = 1'b0;
        set_req(1'b1, 5'd0, 5'd6, 1'b0, 32'hA3, 32'h0);
        flush = 1'b1;
        tick();
        idle();
        checks++; if (pend_count !== '0 || RegWrite !== 1'b0 || wb_drop !== 1'b0) begin
            errors++; $display("FAIL flush_full: got count=%0d RW=%b drop=%b expected 0/0/0", pend_count, RegWrite, wb_drop);
        end
        tick();
        checks++; if (RegWrite !== 1'b0 || pend_count !== '0) begin
            errors++; $display("FAIL flush_after: got RW=%b count=%0d expected 0/0", RegWrite, pend_count);
        end
        // Flush cancels a write on the port; a same-cycle $0 request gives no pulse.
        set_req(1'b1, 5'd0, 5'd7, 1'b0, 32'hB1, 32'h0);
        tick();
        idle();
        tick();
        checks++; if (RegWrite !== 1'b1 || A3 !== 5'd7) begin
            errors++; $display("FAIL flush_pre: got RW=%b A3=%0d expected 1/7", RegWrite, A3);
        end
        set_req(1'b0, 5'd0, 5'd9, 1'b0, 32'hB2, 32'h0);
        flush = 1'b1;
        tick();
        idle();
        checks++; if (RegWrite !== 1'b0 || wb_drop !== 1'b0 || dbg_state !== WB_IDLE) begin
            errors++; $display("FAIL flush_inflight: got RW=%b drop=%b state=%0d expected 0/0/%0d", RegWrite, wb_drop, dbg_state, WB_IDLE);
        end
    endtask

    task automatic test_reset_inflight();
        set_req(1'b1, 5'd0, 5'd8, 1'b1, 32'h0, 32'hBEEF);
        tick();
        idle();
        tick();
        checks++; if (RegWrite !== 1'b1 || A3 !== 5'd8 || WD3 !== 32'hBEEF) begin
            errors++; $display("FAIL rstf_pre: got RW=%b A3=%0d WD3=%h expected 1/8/0000beef", RegWrite, A3, WD3);
        end
        reset = 1'b1;
        tick();
        checks++; if (RegWrite !== 1'b0 || A3 !== '0 || WD3 !== '0 || wb_ready !== 1'b0) begin
            errors++; $display("FAIL rstf_clear: got RW=%b A3=%0d WD3=%h ready=%b expected 0/0/0/0", RegWrite, A3, WD3, wb_ready);
        end
        reset = 1'b0;
        #1;
        checks++; if (wb_ready !== 1'b1 || pend_count !== '0) begin
            errors++; $display("FAIL rstf_release: got ready=%b count=%0d expected 1/0", wb_ready, pend_count);
        end
        tick();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_drop();
        test_hold_full();
        test_flush();
        test_reset_inflight();
        tick();
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d writes never seen, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
